// File: rtl/udp_header_tx.sv
// UDP header prepender: emits an 8-byte UDP header (checksum 0) followed by the
// payload stream, with one output register stage and ready/valid handshakes.
module udp_header_tx #(
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        clock,
  input  logic        sclr,
  input  logic        start,
  input  logic [15:0] src_port,
  input  logic [15:0] dst_port,
  input  logic [15:0] payload_len,
  output logic        busy,
  output logic        len_err,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  dataout,
  output logic        dataen,
  output logic        data_last,
  input  logic        out_ready
);

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned HDR_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD
  } state_t;

  state_t              r_state,     w_state_nxt;
  logic [LEN_W-1:0]    r_src,       w_src_nxt;
  logic [LEN_W-1:0]    r_dst,       w_dst_nxt;
  logic [LEN_W-1:0]    r_len_fld,   w_len_fld_nxt;
  logic [LEN_W-1:0]    r_remaining, w_remaining_nxt;
  logic [CNT_W-1:0]    r_hdr_cnt,   w_hdr_cnt_nxt;
  logic [BYTE_W-1:0]   r_dataout,   w_dataout_nxt;
  logic                r_dataen,    w_dataen_nxt;
  logic                r_last,      w_last_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_len_err,   w_len_err_nxt;

  logic                w_out_xfer;
  logic                w_out_free;
  logic                w_pl_ready;
  logic                w_pl_xfer;
  logic                w_len_bad;
  logic [CNT_W-1:0]    w_hdr_idx;
  logic [BYTE_W-1:0]   w_hdr_byte;

  assign w_out_xfer = r_dataen & out_ready;
  assign w_out_free = ~r_dataen | out_ready;
  assign w_pl_ready = (r_state == S_PAYLOAD) && (r_remaining != '0) && w_out_free;
  assign w_pl_xfer  = pl_valid & w_pl_ready;
  assign w_len_bad  = payload_len > LEN_W'(MAX_PAYLOAD);
  assign w_hdr_idx  = r_hdr_cnt + CNT_W'(1);

  // Header byte that follows the one currently held in the output register
  always_comb begin
    w_hdr_byte = '0;
    case (w_hdr_idx)
      CNT_W'(0): w_hdr_byte = r_src[15:8];
      CNT_W'(1): w_hdr_byte = r_src[7:0];
      CNT_W'(2): w_hdr_byte = r_dst[15:8];
      CNT_W'(3): w_hdr_byte = r_dst[7:0];
      CNT_W'(4): w_hdr_byte = r_len_fld[15:8];
      CNT_W'(5): w_hdr_byte = r_len_fld[7:0];
      default:   w_hdr_byte = '0;
    endcase
  end

  // Next-state and datapath. PAYLOAD is entered as header byte 7 is loaded so
  // the first payload byte can follow it without a bubble.
  always_comb begin
    w_state_nxt     = r_state;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_len_fld_nxt   = r_len_fld;
    w_remaining_nxt = r_remaining;
    w_hdr_cnt_nxt   = r_hdr_cnt;
    w_dataout_nxt   = r_dataout;
    w_dataen_nxt    = r_dataen;
    w_last_nxt      = r_last;
    w_len_err_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_bad) begin
            w_len_err_nxt = 1'b1;
          end else begin
            w_src_nxt       = src_port;
            w_dst_nxt       = dst_port;
            w_len_fld_nxt   = payload_len + LEN_W'(HDR_W);
            w_remaining_nxt = payload_len;
            w_hdr_cnt_nxt   = '0;
            w_dataout_nxt   = src_port[15:8];
            w_dataen_nxt    = 1'b1;
            w_last_nxt      = 1'b0;
            w_state_nxt     = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (w_out_xfer) begin
          if (r_hdr_cnt == CNT_W'(HDR_W - 1)) begin
            w_dataen_nxt = 1'b0;
            w_last_nxt   = 1'b0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_hdr_cnt_nxt = w_hdr_idx;
            w_dataout_nxt = w_hdr_byte;
            w_dataen_nxt  = 1'b1;
            if (w_hdr_idx == CNT_W'(HDR_W - 1)) begin
              w_last_nxt = (r_remaining == '0);
              if (r_remaining != '0) begin
                w_state_nxt = S_PAYLOAD;
              end
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (w_pl_xfer) begin
          w_dataout_nxt   = pl_data;
          w_dataen_nxt    = 1'b1;
          w_last_nxt      = (r_remaining == LEN_W'(1));
          w_remaining_nxt = r_remaining - LEN_W'(1);
        end else if (w_out_xfer) begin
          w_dataen_nxt = 1'b0;
          w_last_nxt   = 1'b0;
          if (r_last) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_dataen_nxt = 1'b0;
        w_last_nxt   = 1'b0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_len_fld   <= '0;
      r_remaining <= '0;
      r_hdr_cnt   <= '0;
      r_dataout   <= '0;
      r_dataen    <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_len_fld   <= w_len_fld_nxt;
      r_remaining <= w_remaining_nxt;
      r_hdr_cnt   <= w_hdr_cnt_nxt;
      r_dataout   <= w_dataout_nxt;
      r_dataen    <= w_dataen_nxt;
      r_last      <= w_last_nxt;
      r_busy      <= w_busy_nxt;
      r_len_err   <= w_len_err_nxt;
    end
  end

  assign busy      = r_busy;
  assign len_err   = r_len_err;
  assign pl_ready  = w_pl_ready;
  assign dataout   = r_dataout;
  assign dataen    = r_dataen;
  assign data_last = r_last;

endmodule

// File: tb/tb_udp_header_tx.sv
// Randomized bench for udp_header_tx: a datagram-level byte-queue model predicts
// the output stream, busy and len_err; handshakes are checked every cycle.
module tb_udp_header_tx;

  logic        clock = 1'b0;
  logic        sclr = 1'b1;
  logic        start = 1'b0;
  logic [15:0] src_port = '0;
  logic [15:0] dst_port = '0;
  logic [15:0] payload_len = '0;
  logic        busy, len_err, pl_ready, dataen, data_last;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic [7:0]  dataout;
  logic        out_ready = 1'b0;

  udp_header_tx #(.MAX_PAYLOAD(1472)) dut (
    .clock(clock), .sclr(sclr), .start(start), .src_port(src_port),
    .dst_port(dst_port), .payload_len(payload_len), .busy(busy), .len_err(len_err),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready), .dataout(dataout),
    .dataen(dataen), .data_last(data_last), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [8:0] exp_q[$];
  logic [7:0] src_q[$];
  int   need = 0;
  int   xfers = 0;
  bit   mdl_busy = 0;
  bit   mdl_len_err = 0;
  bit   rst_chk = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic prev_last = 1'b0;
  int   cyc = 0, t_start = 0, t_first = 0, t_last = 0;
  int   or_pct = 100, pv_pct = 100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_bus();
    if (or_pct < 0) out_ready = ~out_ready;
    else out_ready = ($urandom_range(99) < 32'(or_pct));
    pl_valid = (src_q.size() > 0) && ($urandom_range(99) < 32'(pv_pct));
    pl_data  = (src_q.size() > 0) ? src_q[0] : 8'($urandom);
  endtask

  // One clock cycle: sample at the falling edge, advance the model, return after the rising edge.
  task automatic step();
    bit nb;
    logic [8:0] e;
    logic [7:0] h[8];
    logic [15:0] lf;
    @(negedge clock);
    if (rst_chk) begin
      check("rst_dataen", 32'(dataen), 0);
      check("rst_last", 32'(data_last), 0);
      check("rst_dataout", 32'(dataout), 0);
      check("rst_plready", 32'(pl_ready), 0);
      rst_chk = 0;
    end
    check("busy", 32'(busy), 32'(mdl_busy));
    check("len_err", 32'(len_err), 32'(mdl_len_err));
    if (prev_stall) begin
      check("stall_en", 32'(dataen), 1);
      check("stall_data", 32'(dataout), 32'(prev_data));
      check("stall_last", 32'(data_last), 32'(prev_last));
    end
    check("plready_gate", 32'(pl_ready && (need == 0 || xfers < 7)), 0);
    if (sclr) begin
      mdl_busy = 0; mdl_len_err = 0; rst_chk = 1; need = 0; prev_stall = 0;
      exp_q.delete();
    end else begin
      nb = mdl_busy;
      if (dataen && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'(dataen), 0);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(dataout), 32'(e[7:0]));
          check("last", 32'(data_last), 32'(e[8]));
          if (xfers == 0) t_first = cyc;
          xfers++;
          t_last = cyc;
          if (e[8]) nb = 0;
        end
      end
      if (pl_valid && pl_ready) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        need--;
      end
      mdl_len_err = start && !mdl_busy && (payload_len > 16'd1472);
      if (start && !mdl_busy && payload_len <= 16'd1472) begin
        lf = payload_len + 16'd8;
        h = '{src_port[15:8], src_port[7:0], dst_port[15:8], dst_port[7:0],
              lf[15:8], lf[7:0], 8'h00, 8'h00};
        for (int i = 0; i < 8; i++) exp_q.push_back({(payload_len == 0 && i == 7), h[i]});
        for (int i = 0; i < int'(payload_len); i++)
          exp_q.push_back({(i == int'(payload_len) - 1), src_q[i]});
        nb = 1; need = int'(payload_len); xfers = 0; t_start = cyc;
      end
      prev_stall = dataen && !out_ready;
      prev_data = dataout;
      prev_last = data_last;
      mdl_busy = nb;
    end
    cyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic run_dgram(input logic [15:0] s, input logic [15:0] d, input int len,
                           input int orp, input int pvp, input bit inject, input int abort_at);
    int n;
    bit aborted;
    n = 0; aborted = 0;
    src_q.delete();
    for (int i = 0; i < len + 2; i++) src_q.push_back(8'($urandom));
    or_pct = orp; pv_pct = pvp;
    src_port = s; dst_port = d; payload_len = 16'(len); start = 1'b1;
    drive_bus();
    step();
    start = 1'b0;
    while ((exp_q.size() > 0 || mdl_busy) && n < 20000) begin
      if (inject && n == 3) begin
        start = 1'b1; src_port = ~s; dst_port = ~d; payload_len = 16'd2000;
      end else begin
        start = 1'b0;
      end
      if (abort_at >= 0 && !aborted && xfers == abort_at) begin
        sclr = 1'b1; aborted = 1;
      end else begin
        sclr = 1'b0;
      end
      drive_bus();
      step();
      n++;
    end
    start = 1'b0; sclr = 1'b0;
    check("timeout", 32'(n < 20000), 1);
    if (aborted) begin
      drive_bus();
      step();
    end else begin
      check("excess_untouched", 32'(src_q.size()), 2);
    end
  endtask

  task automatic check_latency(input int len);
    check("lat_first", 32'(t_first - t_start), 1);
    check("lat_total", 32'(t_last - t_start), 32'(8 + len));
  endtask

  initial begin
    sclr = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    step();
    sclr = 1'b0;
    step();

    // Basic datagram, full throughput
    run_dgram(16'h1234, 16'hABCD, 4, 100, 100, 0, -1);
    check_latency(4);
    // Header-only datagram
    run_dgram(16'h0102, 16'h0304, 0, 100, 100, 0, -1);
    check_latency(0);
    // Toggling out_ready with payload gaps
    run_dgram(16'hBEEF, 16'h0050, 3, -1, 60, 0, -1);
    // Oversize rejected, then the largest legal size
    src_q.delete();
    payload_len = 16'd1473; start = 1'b1; out_ready = 1'b1; pl_valid = 1'b0;
    step();
    start = 1'b0;
    repeat (3) step();
    run_dgram(16'h4000, 16'h4001, 1472, 100, 100, 0, -1);
    check_latency(1472);
    // Reset mid-payload, then a clean datagram
    run_dgram(16'h1111, 16'h2222, 10, 100, 100, 0, 10);
    run_dgram(16'h3333, 16'h4444, 2, 100, 100, 0, -1);
    check_latency(2);
    // Start while busy is ignored
    run_dgram(16'h5555, 16'h6666, 5, 100, 100, 1, -1);
    check_latency(5);
    // Randomized back-to-back datagrams
    for (int k = 0; k < 25; k++) begin
      run_dgram(16'($urandom), 16'($urandom), int'($urandom_range(40)),
                int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                bit'($urandom_range(1)), -1);
    end
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
